weight_stream_reader: RTL and testbench
=======================================

// Module: weight_stream_reader
// PURPOSE
//  Read-side sequencer for a layer weight memory (1-cycle registered read: ren/radd -> rdata).
//  On start, sweeps addresses 0..numWeight-1 and presents weights as a valid/ready stream
//  to the neuron MAC. Absorbs MAC backpressure via a 2-entry buffer, so it never drops a word.
// PARAMETERS
//  numWeight     30                  weights per sweep (memory depth)
//  addressWidth  $clog2(numWeight)   memory address width
//  dataWidth     16                  weight width, two's-complement fixed point
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst_n      in   1             asynchronous reset, active-low
//  start      in   1             begin sweep; sampled only when busy=0
//  abort      in   1             synchronous flush to IDLE
//  busy       out  1             high from accepted start until done/abort
//  done       out  1             1-cycle pulse after final beat handshake
//  mem_ren    out  1             weight-memory read enable
//  mem_radd   out  addressWidth  weight-memory read address
//  mem_rdata  in   dataWidth     weight-memory data, valid 1 cycle after mem_ren
//  w_valid    out  1             stream valid
//  w_ready    in   1             stream ready (MAC)
//  w_data     out  dataWidth     stream weight
//  w_last     out  1             high with the beat from address numWeight-1
//  rep_cnt    in   8             sweeps per start (WSR_REPEAT_EN only)
// BEHAVIOUR
//  Reset: busy=0, done=0, mem_ren=0, mem_radd=0, w_valid=0, w_data=0, w_last=0,
//   buffer empty, no read in flight, state IDLE.
//  States:
//   IDLE  -> FETCH on start; addr=0.
//   FETCH -> DRAIN after issuing address numWeight-1 of the final sweep.
//   DRAIN -> IDLE when buffer is empty, nothing is in flight, and the last beat handshook.
//  Read issue: mem_ren=1 in FETCH only when occupancy+inflight < 2 (credit).
//   mem_radd=addr. addr increments per issued read.
//  Capture: mem_rdata is written to the buffer on the cycle after mem_ren, tagged
//   last = (issued addr == numWeight-1).
//  Stream:
//   - w_valid = buffer non-empty; w_data/w_last = head.
//   - Pop on w_valid & w_ready.
//   - w_data and w_last hold stable while w_valid & !w_ready.
//  Latency/throughput:
//   - start sampled at edge E0 -> mem_ren high in cycle after E0 -> w_valid high after E2.
//   - With w_ready=1: one beat per cycle, no bubbles.
//   - 30 beats, then done pulses in the cycle after the w_last handshake.
//  Boundaries:
//   - start while busy: ignored.
//   - abort, including abort with start in the same cycle: abort wins. Returns to IDLE next
//     cycle, buffer emptied, in-flight mem_rdata discarded, no done, busy=0.
//   - start in the done cycle: accepted (busy=0 then).
//   - w_ready low indefinitely: at most 2 reads outstanding; mem_ren stays low until credit.
//   - Addr wrap: after numWeight-1, addr returns to 0 (next sweep) or FETCH ends.
//   - Async reset mid-sweep: immediate return to reset values.
// CONFIGURATION
//  WSR_REPEAT_EN defined:
//   - rep_cnt port present, sampled at start; 0 treated as 1.
//   - Performs rep_cnt back-to-back sweeps with no bubble at the wrap.
//   - w_last marks every sweep end; done pulses once, after the final sweep.
//  WSR_REPEAT_EN undefined:
//   - no rep_cnt port; exactly one sweep per start.
// STRUCTURE
//  Package fnn_wsr_pkg: wsr_state_t enum {IDLE,FETCH,DRAIN}, WSR_BUF_DEPTH=2,
//   rep-counter width constant.
//  Sub-module wsr_skid_buf: 2-entry {last,data} buffer with push/pop/count.
//  Top holds FSM, address and rep counters, credit logic.
// TESTING
//  1. w_ready=1, start pulse -> beats 0..29 equal memory contents in order,
//     w_last on beat 29, done 1 cycle later, busy low after.
//  2. w_ready toggles 1010..., then held low for 10 cycles -> no loss or duplication,
//     mem_ren never leaves >2 outstanding, data stable while stalled.
//  3. abort asserted at beat 12 with 2 words buffered -> next cycle w_valid=0, busy=0,
//     no done; a new start replays from addr 0.
//  4. start asserted during busy, and start+abort in the same cycle -> both ignored,
//     stream unchanged.
//  5. rst_n low mid-sweep -> all outputs at reset values asynchronously;
//     a fresh start after release is correct.
//  6. WSR_REPEAT_EN, rep_cnt=3 -> 90 beats, w_last at 29/59/89, single done;
//     rep_cnt=0 -> 30 beats.

Source files
------------

// File: rtl/fnn_wsr_pkg.sv
// Shared definitions for the weight stream reader.
//  - wsr_state_t : sequencer states (IDLE, FETCH, DRAIN); the encodings are also
//                  exported as plain localparams for code that compares raw bits.
//  - WSR_BUF_DEPTH : entries in the output skid buffer, which is also the read credit.
//  - WSR_CNT_W     : width of a 0..WSR_BUF_DEPTH occupancy count.
//  - WSR_REP_W     : width of the sweeps-per-start counter.
package fnn_wsr_pkg;

    localparam int WSR_BUF_DEPTH = 2;
    localparam int WSR_CNT_W     = $clog2(WSR_BUF_DEPTH + 1);
    localparam int WSR_REP_W     = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DRAIN = ST_DRAIN
    } wsr_state_t;

endpackage

// File: rtl/wsr_skid_buf.sv
// Two-entry {last,data} FIFO sitting between the weight memory read port and
// the stream output. The head entry drives the stream directly.
// Ports:
//  clk, rst_n      clock, asynchronous active-low reset
//  i_flush         empty the buffer (stored words are dropped)
//  i_push          write {i_push_last, i_push_data} at the tail
//  i_pop           advance the head (caller guarantees non-empty)
//  o_count         current occupancy, 0..WSR_BUF_DEPTH
//  o_head_last     last tag of the head entry
//  o_head_data     data of the head entry
module wsr_skid_buf
    import fnn_wsr_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic                 i_push_last,
    input  logic [DW-1:0]        i_push_data,
    input  logic                 i_pop,
    output logic [WSR_CNT_W-1:0] o_count,
    output logic                 o_head_last,
    output logic [DW-1:0]        o_head_data
);

    localparam int PTR_W = $clog2(WSR_BUF_DEPTH);

    logic [DW-1:0]        r_data [WSR_BUF_DEPTH];
    logic                 r_last [WSR_BUF_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [WSR_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, because the head entry feeds the
            // stream outputs directly and they must read zero out of reset.
            for (int i = 0; i < WSR_BUF_DEPTH; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + WSR_CNT_W'(i_push) - WSR_CNT_W'(i_pop);
        end
    end

    assign o_count     = r_count;
    assign o_head_last = r_last[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

endmodule

// File: rtl/weight_stream_reader.sv
// Read-side sequencer for a layer weight memory with a 1-cycle registered read.
// On start it sweeps addresses 0..numWeight-1 and presents the weights as a
// valid/ready stream. A 2-entry skid buffer plus read credit means MAC
// backpressure never loses a word.
// Optional feature macro: WSR_REPEAT_EN adds rep_cnt (sweeps per start,
// 0 treated as 1); sweeps run back to back and done pulses once at the end.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  start        begin a sweep (only looked at while idle)
//  abort        synchronous flush back to IDLE; wins over start
//  rep_cnt      sweeps per start (WSR_REPEAT_EN builds only)
//  busy         high from accepted start until done/abort
//  done         one-cycle pulse after the final beat handshake
//  mem_ren      weight memory read enable
//  mem_radd     weight memory read address
//  mem_rdata    weight memory data, valid one cycle after mem_ren
//  w_valid      stream valid
//  w_ready      stream ready from the MAC
//  w_data       stream weight
//  w_last       marks the beat read from address numWeight-1
module weight_stream_reader
    import fnn_wsr_pkg::*;
#(
    parameter int numWeight    = 30,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
`ifdef WSR_REPEAT_EN
    input  logic [WSR_REP_W-1:0]    rep_cnt,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    input  logic [dataWidth-1:0]    mem_rdata,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [dataWidth-1:0]    w_data,
    output logic                    w_last
);

    wsr_state_t              r_state;
    logic [addressWidth-1:0] r_addr;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic                    r_done;
    logic [WSR_REP_W-1:0]    r_rep_left;

    logic [WSR_CNT_W-1:0]    w_count;
    logic                    w_head_last;
    logic [dataWidth-1:0]    w_head_data;
    logic                    w_pop;
    logic [WSR_CNT_W:0]      w_occ_after_pop;
    logic                    w_credit;
    logic                    w_ren;
    logic                    w_issue_last;
    logic [WSR_REP_W-1:0]    w_rep_init;

    // Sweeps remaining after the first one.
`ifdef WSR_REPEAT_EN
    assign w_rep_init = (rep_cnt == '0) ? '0 : rep_cnt - WSR_REP_W'(1);
`else
    assign w_rep_init = '0;
`endif

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & w_ready;

    // Credit counts the slot freed by this cycle's pop, otherwise a streaming
    // MAC would see a bubble every other beat.
    assign w_occ_after_pop = {1'b0, w_count} + {{WSR_CNT_W{1'b0}}, r_inflight}
                           - {{WSR_CNT_W{1'b0}}, w_pop};
    assign w_credit        = (w_occ_after_pop < (WSR_CNT_W + 1)'(WSR_BUF_DEPTH));

    assign w_ren        = (r_state == FETCH) && w_credit && !abort;
    assign w_issue_last = (r_addr == addressWidth'(numWeight - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_rep_left      <= '0;
        end else if (abort) begin
            // NOTE: state is updated with non-blocking assignments only, so every
            // branch below sees the pre-edge values of all registers.
            r_state    <= IDLE;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_rep_left <= '0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_ren;
            r_inflight_last <= w_issue_last;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= FETCH;
                        r_addr     <= '0;
                        r_rep_left <= w_rep_init;
                    end
                end
                FETCH: begin
                    if (w_ren) begin
                        if (w_issue_last) begin
                            r_addr <= '0;
                            if (r_rep_left == '0) begin
                                r_state <= DRAIN;
                            end else begin
                                r_rep_left <= r_rep_left - WSR_REP_W'(1);
                            end
                        end else begin
                            r_addr <= r_addr + addressWidth'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Final beat leaving an otherwise empty pipeline.
                    if (w_pop && w_head_last && (w_count == WSR_CNT_W'(1)) && !r_inflight) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    wsr_skid_buf #(
        .DW (dataWidth)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (abort),
        .i_push      (r_inflight),
        .i_push_last (r_inflight_last),
        .i_push_data (mem_rdata),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_last (w_head_last),
        .o_head_data (w_head_data)
    );

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign mem_ren  = w_ren;
    assign mem_radd = r_addr;
    assign w_data   = w_head_data;
    assign w_last   = w_head_last;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Self-checking bench for weight_stream_reader. A behavioural model turns each
// accepted start into the full list of beats it must produce; one monitor on
// the falling edge compares handshakes, busy, done, stall stability and the
// outstanding-read bound every cycle. Directed scenarios add literal checks.
module tb_weight_stream_reader;

    localparam int NW = 30;
    localparam int AW = $clog2(NW);
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mem_ren;
    logic [AW-1:0] mem_radd;
    logic [DW-1:0] mem_rdata = '0;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          w_last;
`ifdef WSR_REPEAT_EN
    logic [7:0]    rep_cnt;
`endif

    weight_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
`ifdef WSR_REPEAT_EN
        .rep_cnt   (rep_cnt),
`endif
        .busy      (busy),
        .done      (done),
        .mem_ren   (mem_ren),
        .mem_radd  (mem_radd),
        .mem_rdata (mem_rdata),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    // Weight memory with a one-cycle registered read.
    logic [DW-1:0] mem [NW];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_radd];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + monitor ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          fin;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         b;
    bit            exp_busy = 0;
    bit            exp_done = 0;
    bit            cur_busy;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            outst = 0;
    int            o_next;
    int            n_sweeps;
    int            hs_count = 0;
    int            done_count = 0;
    int            last_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_busy   = 0;
            exp_done   = 0;
            prev_stall = 0;
            outst      = 0;
        end else begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (done) done_count++;
            if (w_valid) check("valid_with_expected_beat", 32'(exp_q.size() != 0), 1);
            if (prev_stall) begin
                check("stall_valid", 32'(w_valid), 1);
                check("stall_data", 32'(w_data), 32'(prev_data));
                check("stall_last", 32'(w_last), 32'(prev_last));
            end
            o_next = outst + int'(mem_ren) - int'(w_valid && w_ready);
            check("outstanding_le_2", 32'(o_next <= 2), 1);

            cur_busy = exp_busy;
            exp_done = 0;
            if (abort) begin
                exp_q.delete();
                exp_busy   = 0;
                prev_stall = 0;
                outst      = 0;
            end else begin
                outst      = o_next;
                prev_stall = w_valid && !w_ready;
                prev_data  = w_data;
                prev_last  = w_last;
                if (w_valid && w_ready && exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(w_data), 32'(b.data));
                    check("beat_last", 32'(w_last), 32'(b.last));
                    hs_count++;
                    if (w_last) last_count++;
                    if (b.fin) begin
                        exp_busy = 0;
                        exp_done = 1;
                    end
                end
                if (start && !cur_busy) begin
                    n_sweeps = 1;
`ifdef WSR_REPEAT_EN
                    n_sweeps = (rep_cnt == 0) ? 1 : int'(rep_cnt);
`endif
                    for (int s = 0; s < n_sweeps; s++) begin
                        for (int a = 0; a < NW; a++) begin
                            b.data = mem[a];
                            b.last = (a == NW - 1);
                            b.fin  = (s == n_sweeps - 1) && (a == NW - 1);
                            exp_q.push_back(b);
                        end
                    end
                    exp_busy = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_counts();
        hs_count   = 0;
        done_count = 0;
        last_count = 0;
    endtask

    task automatic fill_mem();
        for (int a = 0; a < NW; a++) mem[a] = DW'($urandom);
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            tick();
            k++;
        end
        check("idle_within_budget", 32'(busy), 0);
    endtask

    task automatic wait_beats(input int n, input int max_cycles);
        int k = 0;
        while (hs_count < n && k < max_cycles) begin
            tick();
            k++;
        end
        check("beats_within_budget", 32'(hs_count >= n), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        w_ready = 1'b1;
`ifdef WSR_REPEAT_EN
        rep_cnt = 8'd1;
`endif
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_mem_ren", 32'(mem_ren), 0);
        check("reset_w_valid", 32'(w_valid), 0);
        check("reset_w_data", 32'(w_data), 0);
        rst_n = 1'b1;
        tick();

        // 1: free-flowing sweep with latency checks
        clear_counts();
        start_pulse();
        check("lat_ren_after_e0", 32'(mem_ren), 1);
        check("lat_radd_first", 32'(mem_radd), 0);
        check("lat_valid_low_e0", 32'(w_valid), 0);
        tick();
        check("lat_valid_low_e1", 32'(w_valid), 0);
        tick();
        check("lat_valid_high_e2", 32'(w_valid), 1);
        check("lat_first_data", 32'(w_data), 32'(mem[0]));
        wait_idle(200);
        check("t1_done_pulse", 32'(done), 1);
        check("t1_beats", 32'(hs_count), 30);
        check("t1_last_count", 32'(last_count), 1);
        tick();
        check("t1_done_once", 32'(done_count), 1);
        check("t1_done_low_after", 32'(done), 0);
        check("t1_busy_low_after", 32'(busy), 0);

        // 2: toggling ready, then a long stall
        clear_counts();
        fill_mem();
        w_ready = 1'b0;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            w_ready = (i % 2 == 0);
            tick();
        end
        w_ready = 1'b0;
        repeat (10) tick();
        check("t2_stalled_valid", 32'(w_valid), 1);
        check("t2_stalled_no_read", 32'(mem_ren), 0);
        w_ready = 1'b1;
        wait_idle(200);
        check("t2_beats", 32'(hs_count), 30);
        tick();
        check("t2_done_once", 32'(done_count), 1);

        // 3: abort at beat 12 with the buffer full, then replay
        clear_counts();
        start_pulse();
        wait_beats(12, 100);
        w_ready = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_valid_after_abort", 32'(w_valid), 0);
        check("t3_busy_after_abort", 32'(busy), 0);
        check("t3_done_after_abort", 32'(done), 0);
        w_ready = 1'b1;
        repeat (3) tick();
        check("t3_no_done", 32'(done_count), 0);
        check("t3_still_empty", 32'(w_valid), 0);
        clear_counts();
        start_pulse();
        wait_idle(200);
        check("t3_replay_beats", 32'(hs_count), 30);

        // 4: start while busy, and start+abort together while idle
        tick();
        clear_counts();
        start_pulse();
        repeat (5) tick();
        start_pulse();
        wait_idle(200);
        check("t4_beats", 32'(hs_count), 30);
        tick();
        check("t4_done_once", 32'(done_count), 1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t4_abort_wins_busy", 32'(busy), 0);
        check("t4_abort_wins_ren", 32'(mem_ren), 0);
        tick();
        check("t4_abort_wins_valid", 32'(w_valid), 0);

        // 5: asynchronous reset mid-sweep
        clear_counts();
        w_ready = 1'b0;
        start_pulse();
        repeat (6) tick();
        rst_n = 1'b0;
        #2;
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_mem_ren", 32'(mem_ren), 0);
        check("t5_mem_radd", 32'(mem_radd), 0);
        check("t5_w_valid", 32'(w_valid), 0);
        check("t5_w_data", 32'(w_data), 0);
        check("t5_w_last", 32'(w_last), 0);
        w_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        start_pulse();
        wait_idle(200);
        check("t5_restart_beats", 32'(hs_count), 30);

`ifdef WSR_REPEAT_EN
        // 6: repeated sweeps
        tick();
        clear_counts();
        rep_cnt = 8'd3;
        start_pulse();
        wait_idle(400);
        check("t6_rep3_beats", 32'(hs_count), 90);
        check("t6_rep3_lasts", 32'(last_count), 3);
        tick();
        check("t6_rep3_done_once", 32'(done_count), 1);
        clear_counts();
        rep_cnt = 8'd0;
        start_pulse();
        wait_idle(200);
        check("t6_rep0_beats", 32'(hs_count), 30);
        tick();
`endif

        // Randomized phase: random ready, stray starts, rare aborts.
        for (int it = 0; it < 6; it++) begin
            fill_mem();
`ifdef WSR_REPEAT_EN
            rep_cnt = 8'($urandom_range(0, 3));
`endif
            for (int c = 0; c < 400; c++) begin
                w_ready = ($urandom_range(0, 9) < 7);
                start   = ($urandom_range(0, 19) == 0);
                abort   = ($urandom_range(0, 299) == 0);
                tick();
            end
            start   = 1'b0;
            abort   = 1'b0;
            w_ready = 1'b1;
            wait_idle(400);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
